// File: rtl/gtech_rr_arb5.sv
// Five-way round-robin arbiter with registered one-hot grant, hold-until-release
// ownership and an optional hold timeout that revokes a grant held too long.
module gtech_rr_arb5 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5,
  parameter int PTR_INIT = 0
) (
  input  logic       CP,
  input  logic       RST,
  input  logic [4:0] REQ,
  input  logic       DONE,
  output logic [4:0] GNT,
  output logic       GNT_VLD,
  output logic [2:0] GNT_ID,
  output logic       TIMEOUT
);

  localparam int                N         = 5;
  localparam logic [2:0]        PTR_RST   = 3'(PTR_INIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       ptr_reg;

  // Assert asynchronously, release only after two clean edges.
  logic [1:0] rst_sync_reg;
  logic       rst_core;

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      rst_sync_reg <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
  end

  assign rst_core = rst_sync_reg[1];

  // Slot gi of the rotated view holds requester (ptr + gi) mod 5.
  logic [2:0] rot_idx [N];
  logic [N-1:0] rot_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [3:0] rot_sum;
    assign rot_sum     = {1'b0, ptr_reg} + 4'(gi);
    assign rot_idx[gi] = (rot_sum >= 4'd5) ? 3'(rot_sum - 4'd5) : rot_sum[2:0];
    assign rot_req[gi] = REQ[rot_idx[gi]];
  end

  logic       win_vld;
  logic [2:0] win_id;

  always_comb begin
    win_vld = 1'b0;
    win_id  = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_vld = 1'b1;
        win_id  = rot_idx[k];
      end
    end
  end

  logic [N-1:0] win_onehot;

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign win_onehot[gi] = win_vld && (win_id == 3'(gi));
  end

  logic       owner_req;
  logic       hold_expired;
  logic       release_now;
  logic       timeout_hit;
  logic [2:0] next_ptr;

  assign owner_req    = REQ[GNT_ID];
  assign hold_expired = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);
  assign release_now  = DONE || !owner_req || hold_expired;
  // DONE wins over expiry, and a dropped request is a normal release.
  assign timeout_hit  = hold_expired && !DONE && owner_req;
  assign next_ptr     = (GNT_ID == 3'd4) ? 3'd0 : GNT_ID + 3'd1;

  always_ff @(posedge CP or posedge rst_core) begin
    if (rst_core) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= PTR_RST;
      GNT       <= '0;
      GNT_VLD   <= 1'b0;
      GNT_ID    <= 3'd0;
      TIMEOUT   <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_vld) begin
            GNT       <= win_onehot;
            GNT_VLD   <= 1'b1;
            GNT_ID    <= win_id;
            cnt_reg   <= '0;
            state_reg <= OWN;
          end
        end
        OWN: begin
          if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (release_now) begin
            GNT       <= '0;
            GNT_VLD   <= 1'b0;
            GNT_ID    <= 3'd0;
            ptr_reg   <= next_ptr;
            TIMEOUT   <= timeout_hit;
            state_reg <= GAP;
          end
        end
        GAP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtech_rr_arb5.sv
// Directed bench for gtech_rr_arb5: expectations queued per step, popped and
// checked one clock later.
module tb_gtech_rr_arb5;

  logic       CP;
  logic       RST;
  logic [4:0] REQ;
  logic       DONE;
  logic [4:0] GNT;
  logic       GNT_VLD;
  logic [2:0] GNT_ID;
  logic       TIMEOUT;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [4:0] gnt;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  logic [4:0] g_exp;

  gtech_rr_arb5 #(.MAX_HOLD(16), .CNT_W(5), .PTR_INIT(0)) dut (
    .CP      (CP),
    .RST     (RST),
    .REQ     (REQ),
    .DONE    (DONE),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GNT_ID  (GNT_ID),
    .TIMEOUT (TIMEOUT)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] id_of(input logic [4:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input string field,
                     input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%b required=%b", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [4:0] g, input logic t);
    exp_t e;
    e.tag = tag;
    e.gnt = g;
    e.tmo = t;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, "gnt", GNT, e.gnt);
    cmp(e.tag, "vld", {4'd0, GNT_VLD}, {4'd0, |e.gnt});
    cmp(e.tag, "id", {2'd0, GNT_ID}, {2'd0, id_of(e.gnt)});
    cmp(e.tag, "tmo", {4'd0, TIMEOUT}, {4'd0, e.tmo});
  endtask

  task automatic step(input string tag, input logic [4:0] g, input logic t);
    push(tag, g, t);
    @(posedge CP);
    #1;
    check_front();
  endtask

  task automatic chk_now(input string tag, input logic [4:0] g, input logic t);
    push(tag, g, t);
    check_front();
  endtask

  initial begin
    RST  = 1'b0;
    REQ  = 5'b00000;
    DONE = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk_now("rst_async", 5'b00000, 1'b0);
    step("rst_hold0", 5'b00000, 1'b0);
    step("rst_hold1", 5'b00000, 1'b0);
    RST = 1'b0;
    step("rst_rel0", 5'b00000, 1'b0);
    step("rst_rel1", 5'b00000, 1'b0);
    step("idle_noreq", 5'b00000, 1'b0);

    // all requesting, DONE on every third cycle of each ownership
    REQ = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      g_exp = 5'b00001 << (k % 5);
      step($sformatf("rr%0d_gnt", k), g_exp, 1'b0);
      step($sformatf("rr%0d_hold", k), g_exp, 1'b0);
      DONE = 1'b1;
      step($sformatf("rr%0d_rel", k), 5'b00000, 1'b0);
      DONE = 1'b0;
      step($sformatf("rr%0d_gap", k), 5'b00000, 1'b0);
    end

    // owner 4 then wrap to 0; non-owner request change mid-grant
    REQ = 5'b10000;
    step("wrap_gnt4", 5'b10000, 1'b0);
    REQ = 5'b10001;
    step("wrap_hold4", 5'b10000, 1'b0);
    DONE = 1'b1;
    step("wrap_rel4", 5'b00000, 1'b0);
    DONE = 1'b0;
    step("wrap_gap", 5'b00000, 1'b0);
    step("wrap_gnt0", 5'b00001, 1'b0);
    DONE = 1'b1;
    REQ  = 5'b00000;
    step("wrap_rel0", 5'b00000, 1'b0);
    DONE = 1'b0;
    step("wrap_idle", 5'b00000, 1'b0);

    // single requester, DONE, re-grant, then release by dropping REQ
    REQ = 5'b00001;
    step("t1_gnt", 5'b00001, 1'b0);
    DONE = 1'b1;
    step("t1_rel", 5'b00000, 1'b0);
    DONE = 1'b0;
    step("t1_gap", 5'b00000, 1'b0);
    step("t1_regnt", 5'b00001, 1'b0);
    REQ = 5'b00000;
    step("t1_drop", 5'b00000, 1'b0);
    step("t1_idle", 5'b00000, 1'b0);

    // hold timeout: 16 cycles of ownership then forced release
    REQ = 5'b00110;
    step("to_gnt1", 5'b00010, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step($sformatf("to_hold%0d", i), 5'b00010, 1'b0);
    end
    step("to_expire", 5'b00000, 1'b1);
    step("to_gap", 5'b00000, 1'b0);
    step("to_gnt2", 5'b00100, 1'b0);

    // DONE coincides with the last permitted cycle
    for (int i = 0; i < 15; i++) begin
      step($sformatf("dt_hold%0d", i), 5'b00100, 1'b0);
    end
    DONE = 1'b1;
    step("dt_rel", 5'b00000, 1'b0);
    DONE = 1'b0;
    step("dt_gap", 5'b00000, 1'b0);
    step("dt_gnt1", 5'b00010, 1'b0);

    // reset while requester 2 owns the grant
    REQ = 5'b00100;
    step("rs_drop1", 5'b00000, 1'b0);
    step("rs_gap", 5'b00000, 1'b0);
    step("rs_gnt2", 5'b00100, 1'b0);
    RST = 1'b1;
    #1;
    chk_now("rs_async", 5'b00000, 1'b0);
    REQ = 5'b11111;
    step("rs_hold0", 5'b00000, 1'b0);
    step("rs_hold1", 5'b00000, 1'b0);
    RST = 1'b0;
    step("rs_rel0", 5'b00000, 1'b0);
    step("rs_rel1", 5'b00000, 1'b0);
    step("rs_gnt_init", 5'b00001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
